// File: rtl/network.sv
// rtl/network.sv - single-neuron binary classifier using serial spike counting
// Each set pixel emits |weight| unit spikes that raise or lower a balance counter.
module network #(
  parameter int WIDTH = 8,
  parameter int HEIGHT = 7,
  parameter int NUM_POS_WEIGHTS = 3,
  parameter logic [WIDTH:0] WEIGHTS [0:HEIGHT-1] = '{default: (WIDTH+1)'(60)},
  localparam int BW = $clog2(HEIGHT * (2**WIDTH - 1) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HEIGHT-1:0] pixels,
  output logic              neuron_out,
  output logic [BW-1:0]     balance_out
);

  localparam int S  = 2**(WIDTH+1) + 2;
  localparam int CW = $clog2(S);
  localparam int IW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [WIDTH-1:0] MAG_MAX      = '1;
  localparam logic [BW-1:0]    BAL_MAX      = '1;
  localparam logic [CW-1:0]    C_WRAP       = CW'(S - 1);
  localparam logic [CW-1:0]    C_DONE       = CW'(S - 2);
  localparam logic [CW-1:0]    C_SPIKE_LAST = CW'(S - 4);
  localparam logic [IW-1:0]    I_LAST       = IW'(HEIGHT - 1);
  localparam logic [IW:0]      NPOS         = (IW+1)'(NUM_POS_WEIGHTS);

  logic [IW-1:0]    i;
  logic [CW-1:0]    c;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    balance;
  logic             underflow;
  logic             done;
  logic             spike;
  logic             excit;

  always_comb begin
    mag = WEIGHTS[i][WIDTH-1:0];
    // Weights wider than WIDTH bits saturate so the balance stays within BW bits.
    if (WEIGHTS[i] > {1'b0, MAG_MAX}) mag = MAG_MAX;
    spike = !c[0] && (c >= CW'(2)) && (c <= C_SPIKE_LAST) && (cnt != '0);
    excit = ({1'b0, i} < NPOS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i         <= '0;
      c         <= '0;
      cnt       <= '0;
      balance   <= '0;
      underflow <= 1'b0;
      done      <= 1'b0;
    end else if (!done) begin
      if (c == C_WRAP) begin
        c <= '0;
        i <= i + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
      if ((c == C_DONE) && (i == I_LAST)) done <= 1'b1;
      if (c == '0) begin
        cnt <= pixels[i] ? mag : '0;
      end else if (spike) begin
        cnt <= cnt - 1'b1;
        if (excit) begin
          if (balance != BAL_MAX) balance <= balance + 1'b1;
        end else if (balance != '0) begin
          balance <= balance - 1'b1;
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

  assign neuron_out  = done && (balance != '0) && !underflow;
  assign balance_out = balance;

endmodule

// File: tb/tb_network.sv
// tb/tb_network.sv - scoreboard bench for network, default and saturating weights
module tb_network;

  typedef struct {
    int peak;
    int bal;
    int nout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  pixels = '0;
  logic        nout, nout_s;
  logic [10:0] bal, bal_s;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int peak = 0;
  int peak_s = 0;
  int early = 0;
  string name = "";
  exp_t sb[$];
  exp_t sb_sat[$];

  always #5 clk = ~clk;

  network dut (
    .clk(clk), .rst(rst), .pixels(pixels), .neuron_out(nout), .balance_out(bal)
  );

  network #(.WEIGHTS('{default: 9'd260})) dut_sat (
    .clk(clk), .rst(rst), .pixels(pixels), .neuron_out(nout_s), .balance_out(bal_s)
  );

  function automatic exp_t model(input logic [6:0] p, input int w);
    exp_t e;
    int mag, pos, neg;
    mag = (w > 255) ? 255 : w;
    pos = 0;
    neg = 0;
    for (int k = 0; k < 7; k++)
      if (p[k]) begin
        if (k < 3) pos += mag;
        else neg += mag;
      end
    e.peak = pos;
    e.bal  = (pos > neg) ? pos - neg : 0;
    e.nout = (pos > neg) ? 1 : 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s.%s: observed %0d expected %0d", name, tag, obs, exp_v);
    end
  endtask

  task automatic clear_track();
    edge_n = 0;
    peak   = 0;
    peak_s = 0;
    early  = 0;
  endtask

  task automatic start(input string n, input logic [6:0] p);
    name   = n;
    pixels = p;
    sb.push_back(model(p, 60));
    sb_sat.push_back(model(p, 260));
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check("rst_bal", 32'(bal), 0);
    check("rst_bal_sat", 32'(bal_s), 0);
    check("rst_nout", 32'(nout), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    clear_track();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (int'(bal) > peak) peak = int'(bal);
      if (int'(bal_s) > peak_s) peak_s = int'(bal_s);
      if (edge_n < 3597 && (nout !== 1'b0 || nout_s !== 1'b0)) early++;
    end
  endtask

  task automatic finish_run();
    exp_t e, es;
    e  = sb.pop_front();
    es = sb_sat.pop_front();
    check("peak", 32'(peak), 32'(e.peak));
    check("bal", 32'(bal), 32'(e.bal));
    check("nout", 32'(nout), 32'(e.nout));
    check("peak_sat", 32'(peak_s), 32'(es.peak));
    check("bal_sat", 32'(bal_s), 32'(es.bal));
    check("nout_sat", 32'(nout_s), 32'(es.nout));
    check("early_nout", 32'(early), 0);
  endtask

  initial begin
    start("all_on", 7'b1111111);
    run(3600);
    finish_run();

    start("all_off", 7'b0000000);
    run(3600);
    finish_run();

    start("pos_only", 7'b0000111);
    run(3596);
    check("nout_before_done", 32'(nout), 0);
    run(1);
    check("nout_at_done", 32'(nout), 1);
    run(3);
    finish_run();

    start("one_neg", 7'b0001111);
    run(3600);
    finish_run();

    start("mid_reset", 7'b0000111);
    run(1000);
    check("bal_c1000", 32'(bal), 120);
    check("bal_sat_c1000", 32'(bal_s), 497);
    #3 rst = 1'b0;
    #1;
    check("async_bal", 32'(bal), 0);
    check("async_bal_sat", 32'(bal_s), 0);
    check("async_nout", 32'(nout), 0);
    #1 rst = 1'b1;
    clear_track();
    run(3598);
    finish_run();
    run(5);
    check("frozen_bal", 32'(bal), 180);
    check("frozen_nout", 32'(nout), 1);
    check("frozen_bal_sat", 32'(bal_s), 765);

    check("sb_empty", 32'(sb.size() + sb_sat.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
